// File: rtl/cdb_fifo_arbiter.sv
// cdb_fifo_arbiter
// Drains up to NUM_SRC first-word-fall-through result FIFOs onto the single
// Common Data Bus. Each cycle at most one non-empty source is granted and
// popped, and its head word is registered onto the CDB with its source tag.
// Only non-empty sources are ever popped, so a source FIFO never reads while empty.
//
// Optional feature macro: CDB_ARB_ROUND_ROBIN_EN
//   defined   : round-robin search starting at rr_ptr, pointer advances past
//               each granted source.
//   undefined : fixed priority, lowest-index non-empty source wins and
//               rr_ptr stays at 0.
module cdb_fifo_arbiter #(
    parameter int  NUM_SRC = 4,
    parameter int  WIDTH   = 8,
    localparam int TAG_W   = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [0:NUM_SRC-1]       empty,
    input  logic [0:NUM_SRC*WIDTH-1] din,
    input  logic                     cdb_stall,
    output logic [0:NUM_SRC-1]       r_en,
    output logic                     cdb_valid,
    output logic [0:WIDTH-1]         cdb_data,
    output logic [0:TAG_W-1]         cdb_tag,
    output logic [0:TAG_W-1]         rr_ptr
);

    logic             grant_valid;
    logic [TAG_W-1:0] grant_idx;
    logic [TAG_W-1:0] search_start;

    // Find the first non-empty source at or after search_start, wrapping at
    // NUM_SRC (which need not be a power of two); reset and stall veto it.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            int cand;
            cand = int'(search_start) + k;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            if (!grant_valid && !empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = TAG_W'(cand);
            end
        end
        if (reset || cdb_stall) begin
            grant_valid = 1'b0;
        end
    end

    // Pop strobe is one-hot on the granted source, otherwise all zero.
    always_comb begin
        r_en = '0;
        if (grant_valid) begin
            r_en[grant_idx] = 1'b1;
        end
    end

`ifdef CDB_ARB_ROUND_ROBIN_EN
    logic [TAG_W-1:0] rr_ptr_q;
    logic [TAG_W-1:0] next_ptr;

    // Priority moves to the source after the granted one, wrapping to 0.
    always_comb begin
        if (grant_idx == TAG_W'(NUM_SRC - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = grant_idx + TAG_W'(1);
        end
    end

    // Pointer only moves on a real grant, so idle and stalled cycles keep it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else if (grant_valid) begin
            rr_ptr_q <= next_ptr;
        end
    end

    assign search_start = rr_ptr_q;
`else
    assign search_start = '0;
`endif

    assign rr_ptr = search_start;

    // Register the granted head word and its tag; valid is a one-cycle pulse
    // while data and tag hold their last values between beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            cdb_valid <= 1'b0;
            cdb_data  <= '0;
            cdb_tag   <= '0;
        end else if (grant_valid) begin
            cdb_valid <= 1'b1;
            cdb_data  <= din[int'(grant_idx)*WIDTH +: WIDTH];
            cdb_tag   <= grant_idx;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_fifo_arbiter.sv
// tb_cdb_fifo_arbiter
// Self-checking bench for cdb_fifo_arbiter. A 4-source instance is exercised
// with a directed vector table, FIFO-backed directed sequences and random
// traffic against a queue-level reference model; a 3-source instance checks
// the non-power-of-two pointer wrap. Follows CDB_ARB_ROUND_ROBIN_EN.
module tb_cdb_fifo_arbiter;

`ifdef CDB_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cdb_stall = 1'b0;

    logic [0:3]  empty4 = 4'b1111;
    logic [0:31] din4 = '0;
    logic [0:3]  r_en4;
    logic        cdb_valid4;
    logic [0:7]  cdb_data4;
    logic [0:1]  cdb_tag4;
    logic [0:1]  rr_ptr4;

    logic [0:2]  empty3 = 3'b111;
    logic [0:23] din3 = {8'h11, 8'h22, 8'h33};
    logic [0:2]  r_en3;
    logic        cdb_valid3;
    logic [0:7]  cdb_data3;
    logic [0:1]  cdb_tag3;
    logic [0:1]  rr_ptr3;

    int errors = 0;
    int checks = 0;

    // Source FIFO contents as ring buffers with free-running pointers.
    logic [7:0] fmem [0:3][0:63];
    int         fwr [0:3];
    int         frd [0:3];

    // Reference model of the registered CDB side.
    logic       m_valid = 1'b0;
    logic [7:0] m_data = '0;
    int         m_tag = 0;
    int         m_ptr = 0;

    typedef struct {
        logic       rst;
        logic       stall;
        logic [0:3] empty;
        logic [0:3] exp_ren;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [1:0] exp_tag;
        logic [1:0] exp_ptr;
    } vec_t;

    vec_t vecs [0:10];

    cdb_fifo_arbiter #(.NUM_SRC(4), .WIDTH(8)) dut4 (
        .clk(clk), .reset(reset), .empty(empty4), .din(din4),
        .cdb_stall(cdb_stall), .r_en(r_en4), .cdb_valid(cdb_valid4),
        .cdb_data(cdb_data4), .cdb_tag(cdb_tag4), .rr_ptr(rr_ptr4)
    );

    cdb_fifo_arbiter #(.NUM_SRC(3), .WIDTH(8)) dut3 (
        .clk(clk), .reset(reset), .empty(empty3), .din(din3),
        .cdb_stall(cdb_stall), .r_en(r_en3), .cdb_valid(cdb_valid3),
        .cdb_data(cdb_data3), .cdb_tag(cdb_tag3), .rr_ptr(rr_ptr3)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and let them settle.
    task automatic applyStimulus(input logic rst_i, input logic stall_i,
                                 input logic [0:3] emp, input logic [0:31] d);
        @(negedge clk);
        reset     = rst_i;
        cdb_stall = stall_i;
        empty4    = emp;
        din4      = d;
        #1;
    endtask

    task automatic pushWord(input int s, input logic [7:0] v);
        if (fwr[s] - frd[s] < 60) begin
            fmem[s][fwr[s] % 64] = v;
            fwr[s]++;
        end
    endtask

    // Grant = requester at the smallest circular distance from the pointer.
    function automatic int modelGrant(input int n, input int ptr, input logic [15:0] req);
        int best = -1;
        int best_d = n;
        for (int i = 0; i < n; i++) begin
            if (req[i]) begin
                int d = (i - ptr + n) % n;
                if (d < best_d) begin
                    best_d = d;
                    best   = i;
                end
            end
        end
        return best;
    endfunction

    task automatic checkRegs(input string tag);
        checkOutput({tag, "_cdb_valid"}, 32'(cdb_valid4), 32'(m_valid));
        checkOutput({tag, "_cdb_data"},  32'(cdb_data4),  32'(m_data));
        checkOutput({tag, "_cdb_tag"},   32'(cdb_tag4),   m_tag);
        checkOutput({tag, "_rr_ptr"},    32'(rr_ptr4),    m_ptr);
    endtask

    // One clock of the 4-source DUT fed from the FIFO model and checked
    // against the reference model, both combinationally and after the edge.
    task automatic runCycle(input logic rst_i, input logic stall_i);
        logic [0:3]  emp;
        logic [0:31] d;
        logic [15:0] req;
        logic [0:3]  exp_ren;
        logic [0:3]  ren_s;
        int          g;
        emp = 4'b1111;
        d   = '0;
        req = '0;
        for (int i = 0; i < 4; i++) begin
            if (fwr[i] != frd[i]) begin
                emp[i]          = 1'b0;
                req[i]          = 1'b1;
                d[i*8 +: 8]     = fmem[i][frd[i] % 64];
            end
        end
        g = (rst_i || stall_i) ? -1 : modelGrant(4, m_ptr, req);
        applyStimulus(rst_i, stall_i, emp, d);
        exp_ren = '0;
        if (g >= 0) exp_ren[g] = 1'b1;
        checkOutput("r_en", 32'(r_en4), 32'(exp_ren));
        checkOutput("r_fail", 32'(r_en4 & empty4), 32'd0);
        ren_s = r_en4;
        @(posedge clk);
        if (rst_i) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_tag   = 0;
            m_ptr   = 0;
        end else if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = fmem[g][frd[g] % 64];
            m_tag   = g;
            m_ptr   = RR_EN ? (g + 1) % 4 : 0;
        end else begin
            m_valid = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            if (ren_s[i] && fwr[i] != frd[i]) frd[i]++;
        end
        #1;
        checkRegs("model");
    endtask

    // One grant on the 3-source instance with hand-derived expectations.
    task automatic step3(input logic [0:2] emp, input logic [0:2] exp_ren,
                         input logic [7:0] exp_data, input logic [1:0] exp_tag,
                         input logic [1:0] exp_ptr);
        @(negedge clk);
        reset     = 1'b0;
        cdb_stall = 1'b0;
        empty3    = emp;
        #1;
        checkOutput("n3_r_en", 32'(r_en3), 32'(exp_ren));
        @(posedge clk);
        #1;
        checkOutput("n3_cdb_valid", 32'(cdb_valid3), 32'd1);
        checkOutput("n3_cdb_data",  32'(cdb_data3),  32'(exp_data));
        checkOutput("n3_cdb_tag",   32'(cdb_tag3),   32'(exp_tag));
        checkOutput("n3_rr_ptr",    32'(rr_ptr3),    32'(exp_ptr));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            fwr[i] = 0;
            frd[i] = 0;
        end

        vecs[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0, 2'd0};
        vecs[1]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0, 2'd0};
        vecs[2]  = '{1'b0, 1'b0, 4'b1101, 4'b0010, 1'b1, 8'hCC, 2'd2, RR_EN ? 2'd3 : 2'd0};
        vecs[3]  = '{1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 8'hCC, 2'd2, RR_EN ? 2'd3 : 2'd0};
        vecs[4]  = '{1'b0, 1'b0, 4'b0110, RR_EN ? 4'b0001 : 4'b1000, 1'b1,
                     RR_EN ? 8'hDD : 8'hAA, RR_EN ? 2'd3 : 2'd0, 2'd0};
        vecs[5]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0,
                     RR_EN ? 8'hDD : 8'hAA, RR_EN ? 2'd3 : 2'd0, 2'd0};
        vecs[6]  = '{1'b0, 1'b0, 4'b1110, 4'b0001, 1'b1, 8'hDD, 2'd3, 2'd0};
        vecs[7]  = '{1'b0, 1'b0, 4'b0101, 4'b1000, 1'b1, 8'hAA, 2'd0, RR_EN ? 2'd1 : 2'd0};
        vecs[8]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0, 2'd0};
        vecs[9]  = '{1'b0, 1'b0, 4'b0011, 4'b1000, 1'b1, 8'hAA, 2'd0, RR_EN ? 2'd1 : 2'd0};
        vecs[10] = '{1'b0, 1'b0, 4'b0011, RR_EN ? 4'b0100 : 4'b1000, 1'b1,
                     RR_EN ? 8'hBB : 8'hAA, RR_EN ? 2'd1 : 2'd0, RR_EN ? 2'd2 : 2'd0};

        $display("[TB] start, round-robin=%0d", RR_EN);

        // Reset held 3 cycles with every source non-empty: nothing popped.
        for (int i = 0; i < 4; i++) begin
            pushWord(i, 8'(8'h40 + i));
            pushWord(i, 8'(8'h50 + i));
        end
        for (int c = 0; c < 3; c++) runCycle(1'b1, 1'b0);
        checkOutput("reset_no_pop",
                    32'((fwr[0]-frd[0]) + (fwr[1]-frd[1]) + (fwr[2]-frd[2]) + (fwr[3]-frd[3])), 32'd8);
        for (int i = 0; i < 4; i++) frd[i] = fwr[i];

        // Directed vector table on raw inputs.
        for (int k = 0; k < 11; k++) begin
            applyStimulus(vecs[k].rst, vecs[k].stall, vecs[k].empty, 32'hAABBCCDD);
            checkOutput($sformatf("vec%0d_r_en", k), 32'(r_en4), 32'(vecs[k].exp_ren));
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_cdb_valid", k), 32'(cdb_valid4), 32'(vecs[k].exp_valid));
            checkOutput($sformatf("vec%0d_cdb_data", k),  32'(cdb_data4),  32'(vecs[k].exp_data));
            checkOutput($sformatf("vec%0d_cdb_tag", k),   32'(cdb_tag4),   32'(vecs[k].exp_tag));
            checkOutput($sformatf("vec%0d_rr_ptr", k),    32'(rr_ptr4),    32'(vecs[k].exp_ptr));
        end

        // Resynchronise the model with the DUT.
        runCycle(1'b1, 1'b0);

        // Only source 2, three entries, drained then idle.
        pushWord(2, 8'd5);
        pushWord(2, 8'd6);
        pushWord(2, 8'd7);
        for (int c = 0; c < 5; c++) runCycle(1'b0, 1'b0);
        checkOutput("src2_drained", 32'(fwr[2] - frd[2]), 32'd0);

        // All sources kept non-empty, with a 2-cycle stall mid-stream.
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < 4; i++) begin
                while (fwr[i] - frd[i] < 2) pushWord(i, 8'($urandom_range(0, 255)));
            end
            runCycle(1'b0, (c == 7 || c == 8) ? 1'b1 : 1'b0);
        end

        // Random traffic, stalls and occasional resets.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 2) == 0) pushWord(i, 8'($urandom_range(0, 255)));
            end
            runCycle(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0);
        end

        // Flush, reset, then the 3-source wrap sequence.
        for (int i = 0; i < 4; i++) frd[i] = fwr[i];
        runCycle(1'b1, 1'b0);
        runCycle(1'b0, 1'b0);
        step3(3'b101, 3'b010, 8'h22, 2'd1, RR_EN ? 2'd2 : 2'd0);
        step3(3'b010, RR_EN ? 3'b001 : 3'b100, RR_EN ? 8'h33 : 8'h11,
              RR_EN ? 2'd2 : 2'd0, 2'd0);
        step3(3'b010, 3'b100, 8'h11, 2'd0, RR_EN ? 2'd1 : 2'd0);
        @(negedge clk);
        empty3 = 3'b111;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cdb_fifo_arbiter.md
# cdb_fifo_arbiter

Round-robin read arbiter that drains up to NUM_SRC functional-unit result FIFOs (sync_fifo instances) onto the single Common Data Bus. Each cycle it grants at most one non-empty source, pops it via that FIFO's r_en and registers the head word plus a source tag onto the CDB. It sits between the functional-unit output FIFOs and the reservation-station/ROB broadcast logic, and guarantees a sync_fifo never sees a read while empty, so r_fail never fires.

## Interface
- NUM_SRC, 4: number of source FIFOs; legal range 2..16; need not be a power of two.
- WIDTH, 8: CDB data width; equals the source FIFOs' WIDTH.
- TAG_W, $clog2(NUM_SRC): source tag width (localparam).

- clk  in  1  single clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- empty  in  [0:NUM_SRC-1]  empty flag of each source FIFO; bit i is source i.
- din  in  [0:NUM_SRC*WIDTH-1]  head word of each source; source i occupies bits [i*WIDTH : i*WIDTH+WIDTH-1].
- cdb_stall  in  1  consumer cannot take a new beat; blocks any new grant.
- r_en  out  [0:NUM_SRC-1]  pop strobe to each source FIFO; one-hot or all-zero.
- cdb_valid  out  1  registered, one-cycle pulse per transferred word.
- cdb_data  out  [0:WIDTH-1]  registered word.
- cdb_tag  out  [0:TAG_W-1]  registered index of the source that produced cdb_data.
- rr_ptr  out  [0:TAG_W-1]  current highest-priority source (debug/verification).

## Operation
- Source FIFOs are first-word-fall-through: din slice i is valid whenever empty[i]=0; r_en[i] high at an edge pops that word.
- Grant logic is combinational: req[i] = ~empty[i]; grant is valid when ~reset and ~cdb_stall and any req is set.
- Round-robin search starts at rr_ptr and wraps modulo NUM_SRC (non-power-of-two wrap from NUM_SRC-1 to 0); the first requester found is granted.
- r_en = one-hot(grant idx) when grant is valid, else all zero. r_en[i] is never high while empty[i]=1.
- On the edge with a valid grant to idx: cdb_valid<=1, cdb_data<=din slice idx, cdb_tag<=idx, rr_ptr<=(idx+1) mod NUM_SRC.
- With no grant: cdb_valid<=0; cdb_data, cdb_tag and rr_ptr hold.
- cdb_stall only prevents new pops. A beat already on the CDB is not held; the consumer must accept every cdb_valid beat.
- Reset values: cdb_valid=0, cdb_data=0, cdb_tag=0, rr_ptr=0. r_en is all zero throughout reset.
- Reset mid-operation: an asserted request is dropped with no pop, and the next grant after reset starts from source 0.

## Timing
- Grant to CDB latency is 1 cycle: r_en high in cycle t gives cdb_valid high in cycle t+1.
- Throughput is one word per cycle when any source is non-empty and cdb_stall=0.
- cdb_stall is sampled combinationally in the same cycle it gates r_en.
- Fairness bound: a continuously non-empty source waits at most NUM_SRC-1 grants.
- empty rising in the same cycle as a would-be grant gives no grant to that source; the search moves to the next requester.

## Configuration
- CDB_ARB_ROUND_ROBIN_EN defined: round-robin behaviour as specified above.
- CDB_ARB_ROUND_ROBIN_EN undefined: fixed priority, where the lowest-index non-empty source wins. rr_ptr is held at 0 and the fairness bound does not apply. All other behaviour, including latency and reset values, is unchanged.

## Test plan
- Reset held 3 cycles with empty=4'b0000: r_en=0 every cycle, and cdb_valid=0, cdb_data=0, cdb_tag=0, rr_ptr=0 after reset.
- Only source 2 non-empty with 3 entries (values 5, 6, 7): r_en=4'b0010 for 3 consecutive cycles, then CDB shows tag 2 with data 5, 6, 7 on the next 3 cycles; r_en=0 once empty[2]=1 and the FIFO's r_fail never asserts.
- All 4 sources non-empty and continuously refilled: tags 0,1,2,3,0,1,… on consecutive cycles. With the macro undefined, the tag is 0 every cycle.
- All sources non-empty, cdb_stall held high 2 cycles mid-stream: r_en=0 for those 2 cycles, cdb_valid=0 one cycle later, and arbitration resumes at the source after the last granted one.
- NUM_SRC=3, only source 2 non-empty and granted: rr_ptr wraps to 0; then sources 0 and 2 both non-empty gives source 0 granted first.
- Reset asserted in a cycle with requests pending: no r_en that cycle, no pop in the FIFOs, and cdb_valid=0 the following cycle.
